// File: rtl/gsm_sms_tx_pkg.sv
// Shared definitions for the GSM SMS transmitter.
//   state_t      : FSM state encoding
//   req_t        : one metering request {energy, level}
//   ASC_*        : ASCII constants used in the frame "E=ddddd,L\r"
//   FRAME_LEN    : bytes per SMS frame
//   dd_adjust()  : double-dabble "add 3 if >= 5" step over five BCD digits
//   level_char() : alert level -> 'N' / 'W' / 'C'
package gsm_sms_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_CONVERT, S_LOAD, S_TX, S_WAIT_ACK, S_DONE, S_FAIL
  } state_t;

  typedef struct packed {
    logic [15:0] energy;
    logic [1:0]  level;
  } req_t;

  localparam logic [7:0] ASC_E     = 8'h45;
  localparam logic [7:0] ASC_EQ    = 8'h3D;
  localparam logic [7:0] ASC_COMMA = 8'h2C;
  localparam logic [7:0] ASC_N     = 8'h4E;
  localparam logic [7:0] ASC_W     = 8'h57;
  localparam logic [7:0] ASC_C     = 8'h43;
  localparam logic [7:0] ASC_CR    = 8'h0D;
  localparam logic [7:0] ASC_0     = 8'h30;
  localparam int         FRAME_LEN = 10;

  function automatic logic [19:0] dd_adjust(input logic [19:0] v);
    logic [19:0] r;
    r = v;
    for (int i = 0; i < 5; i++)
      if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
    return r;
  endfunction

  // Level 3 is reported as critical, same as 2.
  function automatic logic [7:0] level_char(input logic [1:0] l);
    case (l)
      2'd0:    return ASC_N;
      2'd1:    return ASC_W;
      default: return ASC_C;
    endcase
  endfunction

endpackage

// File: rtl/gsm_sms_tx_uart.sv
// uart_tx_8n1: single-byte UART transmitter, 8 data bits, no parity, 1 stop bit.
//   clk, reset : clock, synchronous active-high reset
//   valid/data : byte offer; taken when valid && ready
//   ready      : idle, or in the final cycle of the stop bit (allows back-to-back bytes)
//   tx         : serial line, idle high, LSB first
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [9:0]    frame;   // {stop, data, start}; frame[0] is the bit on the line
  logic          last;

  assign last  = active && (bit_idx == 4'd9) && (cnt == CW'(CLKS_PER_BIT - 1));
  assign ready = !active || last;

  always_ff @(posedge clk) begin
    if (reset) begin
      active  <= 1'b0;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= '1;
      tx      <= 1'b1;
    end else if (valid && ready) begin
      active  <= 1'b1;
      cnt     <= '0;
      bit_idx <= '0;
      frame   <= {1'b1, data, 1'b0};
      tx      <= 1'b0;
    end else if (active) begin
      if (cnt == CW'(CLKS_PER_BIT - 1)) begin
        cnt <= '0;
        if (bit_idx == 4'd9) begin
          active <= 1'b0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
          frame   <= {1'b1, frame[9:1]};
          tx      <= frame[1];
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/gsm_sms_tx.sv
// gsm_sms_tx: formats a metering request into "E=ddddd,L\r" and sends it to the
// GSM modem over UART 8N1, waiting for OK with retry on error/timeout.
//   clk, reset              : clock, synchronous active-high reset
//   send, energy_units,
//   alert_level             : request strobe and its payload
//   modem_cts               : modem ready, checked before each byte
//   modem_ok, modem_err     : frame acknowledge / negative acknowledge
//   uart_tx                 : serial line to the modem
//   busy                    : request in progress
//   sms_done, sms_fail      : 1-cycle completion pulses
//   drop_count              : saturating count of overwritten pending requests
module gsm_sms_tx
  import gsm_sms_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4,
  parameter int ACK_TIMEOUT  = 1000,
  parameter int MAX_RETRY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send,
  input  logic [15:0] energy_units,
  input  logic [1:0]  alert_level,
  input  logic        modem_cts,
  input  logic        modem_ok,
  input  logic        modem_err,
  output logic        uart_tx,
  output logic        busy,
  output logic        sms_done,
  output logic        sms_fail,
  output logic [7:0]  drop_count
);

  localparam int AW = $clog2(ACK_TIMEOUT + 1);
  localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  state_t        state;
  req_t          slot;
  logic          slot_full;
  logic [1:0]    level_r;
  logic [15:0]   bin;
  logic [19:0]   bcd, bcd_adj;
  logic [3:0]    step;
  logic [3:0]    byte_idx;
  logic          tx_valid, tx_ready;
  logic [7:0]    tx_data, frame_byte;
  logic [AW-1:0] ack_cnt;
  logic [RW-1:0] retries;
  logic          busy_r, done_r, fail_r;
  logic [7:0]    drop_r;

  assign busy       = busy_r;
  assign sms_done   = done_r;
  assign sms_fail   = fail_r;
  assign drop_count = drop_r;

  always_comb bcd_adj = dd_adjust(bcd);

  always_comb begin
    frame_byte = ASC_CR;
    case (byte_idx)
      4'd0: frame_byte = ASC_E;
      4'd1: frame_byte = ASC_EQ;
      4'd2: frame_byte = ASC_0 + {4'd0, bcd[19:16]};
      4'd3: frame_byte = ASC_0 + {4'd0, bcd[15:12]};
      4'd4: frame_byte = ASC_0 + {4'd0, bcd[11:8]};
      4'd5: frame_byte = ASC_0 + {4'd0, bcd[7:4]};
      4'd6: frame_byte = ASC_0 + {4'd0, bcd[3:0]};
      4'd7: frame_byte = ASC_COMMA;
      4'd8: frame_byte = level_char(level_r);
      default: frame_byte = ASC_CR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      slot      <= '0;
      slot_full <= 1'b0;
      level_r   <= '0;
      bin       <= '0;
      bcd       <= '0;
      step      <= '0;
      byte_idx  <= '0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
      ack_cnt   <= '0;
      retries   <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      fail_r    <= 1'b0;
      drop_r    <= '0;
    end else begin
      // Any request arriving outside IDLE (including DONE/FAIL) parks in the slot.
      if (send && state != S_IDLE) begin
        slot      <= {energy_units, alert_level};
        slot_full <= 1'b1;
        if (slot_full && drop_r != 8'hFF) drop_r <= drop_r + 8'd1;
      end

      case (state)
        S_IDLE: begin
          if (send || slot_full) begin
            // A fresh strobe beats the parked request, which is then lost.
            level_r <= send ? alert_level  : slot.level;
            bin     <= send ? energy_units : slot.energy;
            if (send && slot_full && drop_r != 8'hFF) drop_r <= drop_r + 8'd1;
            slot_full <= 1'b0;
            bcd       <= '0;
            step      <= '0;
            busy_r    <= 1'b1;
            state     <= S_CONVERT;
          end
        end

        S_CONVERT: begin
          bcd  <= {bcd_adj[18:0], bin[15]};
          bin  <= {bin[14:0], 1'b0};
          step <= step + 4'd1;
          if (step == 4'd15) begin
            byte_idx <= '0;
            state    <= S_LOAD;
          end
        end

        S_LOAD: begin
          if (modem_cts) begin
            tx_valid <= 1'b1;
            tx_data  <= frame_byte;
            state    <= S_TX;
          end
        end

        // ready with no offer pending means the byte is in its last stop cycle.
        S_TX: begin
          if (tx_valid) begin
            if (tx_ready) tx_valid <= 1'b0;
          end else if (tx_ready) begin
            if (byte_idx == 4'(FRAME_LEN - 1)) begin
              ack_cnt <= '0;
              state   <= S_WAIT_ACK;
            end else begin
              byte_idx <= byte_idx + 4'd1;
              state    <= S_LOAD;
            end
          end
        end

        S_WAIT_ACK: begin
          if (modem_ok) begin
            done_r <= 1'b1;
            state  <= S_DONE;
          end else if (modem_err || ack_cnt == AW'(ACK_TIMEOUT - 1)) begin
            if (retries < RW'(MAX_RETRY)) begin
              retries  <= retries + RW'(1);
              byte_idx <= '0;
              state    <= S_LOAD;
            end else begin
              fail_r <= 1'b1;
              state  <= S_FAIL;
            end
          end else begin
            ack_cnt <= ack_cnt + AW'(1);
          end
        end

        S_DONE, S_FAIL: begin
          done_r  <= 1'b0;
          fail_r  <= 1'b0;
          retries <= '0;
          busy_r  <= 1'b0;
          state   <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  uart_tx_8n1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_uart (
    .clk   (clk),
    .reset (reset),
    .valid (tx_valid),
    .data  (tx_data),
    .ready (tx_ready),
    .tx    (uart_tx)
  );

endmodule

// File: tb/tb_gsm_sms_tx.sv
// Bench for gsm_sms_tx: a line decoder rebuilds bytes from uart_tx, and each
// frame is compared with the text the request should produce.
module tb_gsm_sms_tx;

  localparam int CPB = 4;
  localparam int TMO = 100;
  localparam int MR  = 2;

  logic        clk = 1'b0, reset = 1'b1, send = 1'b0;
  logic        modem_cts = 1'b1, modem_ok = 1'b0, modem_err = 1'b0;
  logic [15:0] energy_units = '0;
  logic [1:0]  alert_level = '0;
  logic        uart_tx, busy, sms_done, sms_fail;
  logic [7:0]  drop_count;

  int cyc = 0, n_chk = 0, n_err = 0;
  int n_done = 0, n_fail = 0, done_cyc = 0;
  int t_send = 0;
  byte unsigned rx_q[$];
  int           rx_st[$];

  gsm_sms_tx #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(TMO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .send(send), .energy_units(energy_units),
    .alert_level(alert_level), .modem_cts(modem_cts), .modem_ok(modem_ok),
    .modem_err(modem_err), .uart_tx(uart_tx), .busy(busy), .sms_done(sms_done),
    .sms_fail(sms_fail), .drop_count(drop_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sms_done === 1'b1) begin n_done++; done_cyc = cyc; end
    if (sms_fail === 1'b1) n_fail++;
  end

  // Line decoder: sample each bit near its middle; record start-bit cycle.
  initial begin : mon
    byte unsigned b;
    int st;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        st = cyc;
        b  = 0;
        repeat (CPB/2) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
          repeat (CPB) @(negedge clk);
          b[k] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        repeat (CPB/2 - 1) @(negedge clk);
        rx_q.push_back(b);
        rx_st.push_back(st);
      end
    end
  end

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic string frame_str(input int e, input int l);
    string lc;
    lc = (l == 0) ? "N" : (l == 1) ? "W" : "C";
    return $sformatf("E=%05d,%s\r", e, lc);
  endfunction

  task automatic send_req(input int e, input int l);
    energy_units = 16'(e);
    alert_level  = 2'(l);
    send         = 1'b1;
    t_send       = cyc;
    @(negedge clk);
    send = 1'b0;
  endtask

  task automatic wait_bytes(input int n);
    int b = 0;
    while (rx_q.size() < n && b < 4000) begin
      @(negedge clk);
      b++;
    end
    if (rx_q.size() < n) chk("rx_timeout", rx_q.size(), n);
  endtask

  task automatic chk_frame(input string tag, input int base, input int e, input int l);
    string s;
    int mg = 0;
    s = frame_str(e, l);
    for (int i = 0; i < 10; i++)
      if (base + i < rx_q.size())
        chk($sformatf("%s_b%0d", tag, i), rx_q[base+i], s[i]);
    if (base + 9 < rx_st.size()) begin
      for (int i = 1; i < 10; i++)
        if (rx_st[base+i] - rx_st[base+i-1] - 10*CPB > mg)
          mg = rx_st[base+i] - rx_st[base+i-1] - 10*CPB;
      chk({tag, "_gap"}, mg <= 2, 1);
    end
  endtask

  task automatic pulse_ok();
    repeat (5) @(negedge clk);
    modem_ok = 1'b1;
    @(negedge clk);
    modem_ok = 1'b0;
  endtask

  task automatic pulse_err();
    repeat (5) @(negedge clk);
    modem_err = 1'b1;
    @(negedge clk);
    modem_err = 1'b0;
  endtask

  task automatic run_ok(input string tag, input int e, input int l);
    int base, d0;
    base = rx_q.size();
    d0   = n_done;
    send_req(e, l);
    wait_bytes(base + 10);
    chk_frame(tag, base, e, l);
    pulse_ok();
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, n_done - d0, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin : main
    int base, d0, f0, rc, gap, lowcnt;
    string s;

    repeat (3) @(negedge clk);
    chk("rst_tx", uart_tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", sms_done, 0);
    chk("rst_fail", sms_fail, 0);
    chk("rst_drop", drop_count, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: basic frame, latency, done pulse, busy drop
    base = rx_q.size();
    d0   = n_done;
    send_req(123, 0);
    rc = t_send;
    wait_bytes(base + 10);
    if (rx_st.size() > base) chk("t1_latency", rx_st[base] - (rc + 1), 18);
    chk_frame("t1", base, 123, 0);
    pulse_ok();
    rc = 0;
    while (sms_done !== 1'b1 && rc < 10) begin @(negedge clk); rc++; end
    chk("t1_done_pulse", sms_done, 1);
    chk("t1_busy_at_done", busy, 1);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);
    chk("t1_ndone", n_done - d0, 1);

    // 2: boundary values, then random requests
    run_ok("t2_max", 65535, 3);
    run_ok("t2_zero", 0, 1);
    for (int k = 0; k < 3; k++)
      run_ok($sformatf("rnd%0d", k), int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)));

    // 3: no acknowledge -> three frames then fail
    base = rx_q.size();
    d0 = n_done; f0 = n_fail;
    send_req(4242, 2);
    for (int k = 0; k < 3; k++) begin
      wait_bytes(base + 10*(k+1));
      chk_frame($sformatf("t3_f%0d", k), base + 10*k, 4242, 2);
      if (k > 0 && rx_st.size() > base + 10*k) begin
        gap = rx_st[base+10*k] - (rx_st[base+10*k-1] + 10*CPB);
        chk($sformatf("t3_retry_gap%0d", k), gap >= TMO && gap <= TMO + 3, 1);
      end
    end
    rc = 0;
    while (n_fail == f0 && rc < 300) begin @(negedge clk); rc++; end
    repeat (150) @(negedge clk);
    chk("t3_nfail", n_fail - f0, 1);
    chk("t3_ndone", n_done - d0, 0);
    chk("t3_nbytes", rx_q.size() - base, 30);

    // 4: error then ok -> two frames, done, no fail
    base = rx_q.size();
    d0 = n_done; f0 = n_fail;
    send_req(999, 1);
    wait_bytes(base + 10);
    pulse_err();
    wait_bytes(base + 20);
    chk_frame("t4_f1", base + 10, 999, 1);
    pulse_ok();
    repeat (150) @(negedge clk);
    chk("t4_ndone", n_done - d0, 1);
    chk("t4_nfail", n_fail - f0, 0);
    chk("t4_nbytes", rx_q.size() - base, 20);

    // 5: pending slot overwrite; latest request served right after DONE
    base = rx_q.size();
    d0 = n_done;
    send_req(777, 0);
    repeat (5) @(negedge clk);
    send_req(50, 1);
    repeat (3) @(negedge clk);
    send_req(100, 2);
    wait_bytes(base + 10);
    chk_frame("t5_f0", base, 777, 0);
    pulse_ok();
    rc = 0;
    while (n_done == d0 && rc < 20) begin @(negedge clk); rc++; end
    wait_bytes(base + 20);
    if (rx_st.size() > base + 10) chk("t5_slot_lat", rx_st[base+10] - done_cyc, 20);
    chk_frame("t5_f1", base + 10, 100, 2);
    chk("t5_drop", drop_count, 1);
    pulse_ok();
    repeat (100) @(negedge clk);
    chk("t5_ndone", n_done - d0, 2);
    chk("t5_nbytes", rx_q.size() - base, 20);

    // 6: CTS hold before byte 3, then reset during byte 5
    base = rx_q.size();
    send_req(4321, 2);
    wait_bytes(base + 3);
    modem_cts = 1'b0;
    lowcnt = 0;
    repeat (200) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) lowcnt++;
    end
    chk("t6_hold_line", lowcnt, 0);
    chk("t6_hold_bytes", rx_q.size() - base, 3);
    rc = cyc;
    modem_cts = 1'b1;
    wait_bytes(base + 5);
    if (rx_st.size() > base + 3) begin
      gap = rx_st[base+3] - rc;
      chk("t6_resume", gap >= 1 && gap <= 3, 1);
    end
    s = frame_str(4321, 2);
    for (int i = 0; i < 5; i++)
      if (base + i < rx_q.size()) chk($sformatf("t6_b%0d", i), rx_q[base+i], s[i]);
    repeat (10) @(negedge clk);
    d0 = n_done; f0 = n_fail;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_tx", uart_tx, 1);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_drop", drop_count, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (300) @(negedge clk);
    chk("t6_ndone", n_done - d0, 0);
    chk("t6_nfail", n_fail - f0, 0);
    chk("t6_busy", busy, 0);
    chk("t6_line", uart_tx, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
